ex_mem_stage: RTL and testbench

//  EX->MEM pipeline stage directly downstream of the integer/FP ALU.
//  - Captures ALU outputs plus EX-stage control into a 2-entry skid buffer.
//  - Normalises set-type results and presents one instruction per cycle to MEM over valid/ready.
//  - Drives forwarding taps for the hazard/bypass unit.

---
 rtl/ex_mem_if.sv | 49 ++++
 rtl/ex_mem_stage.sv | 128 ++++++++++++
 tb/tb_ex_mem_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_if.sv
// EX->MEM stage bus: upstream capture from EX, downstream head toward MEM, bypass taps.
// master = EX/MEM environment, slave = the ex_mem_stage itself.
interface ex_mem_if #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 5
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [DW-1:0]  in_result;
    logic           in_set;
    logic           in_zero;
    logic           in_overflow;
    logic [RW-1:0]  in_rd;
    logic           in_reg_write;
    logic           in_mem_read;
    logic           in_mem_write;
    logic [DW-1:0]  in_store_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_value;
    logic           out_zero;
    logic [RW-1:0]  out_rd;
    logic           out_reg_write;
    logic           out_mem_read;
    logic           out_mem_write;
    logic [DW-1:0]  out_store_data;
    logic           fwd_valid;
    logic [RW-1:0]  fwd_rd;
    logic [DW-1:0]  fwd_data;
    logic           fwd_busy;
    logic           trap_ovf;

    modport master (
        output flush, in_valid, in_op, in_result, in_set, in_zero, in_overflow, in_rd,
               in_reg_write, in_mem_read, in_mem_write, in_store_data, out_ready,
        input  in_ready, out_valid, out_value, out_zero, out_rd, out_reg_write, out_mem_read,
               out_mem_write, out_store_data, fwd_valid, fwd_rd, fwd_data, fwd_busy, trap_ovf
    );

    modport slave (
        input  flush, in_valid, in_op, in_result, in_set, in_zero, in_overflow, in_rd,
               in_reg_write, in_mem_read, in_mem_write, in_store_data, out_ready,
        output in_ready, out_valid, out_value, out_zero, out_rd, out_reg_write, out_mem_read,
               out_mem_write, out_store_data, fwd_valid, fwd_rd, fwd_data, fwd_busy, trap_ovf
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: 2-entry skid buffer with sltu normalisation and forwarding taps.
// Define EXMEM_OVF_TRAP_EN to squash writes of overflowing add/sub and raise sticky trap_ovf.
module ex_mem_stage #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 5
) (
    input logic     clk,
    input logic     reset,
    ex_mem_if.slave bus
);
    // state | meaning
    // EMPTY | no entries held
    // ONE   | head valid, skid empty
    // FULL  | head and skid valid, in_ready low
    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    typedef struct packed {
        logic [DW-1:0] value;
        logic          zero;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic [DW-1:0] store_data;
    } entry_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(5'b00111);

    occ_t   state, state_nxt;
    entry_t head, skid, captured;
    logic   accept, pop, ovf_hit;
    logic   load_head_in, load_head_skid, load_skid;
    logic   trap_q;

    // flush dominates both handshakes
    assign accept = bus.in_valid && (state != FULL) && !bus.flush;
    assign pop    = (state != EMPTY) && bus.out_ready && !bus.flush;

    always_comb begin
        captured.value      = (bus.in_op == OP_SLTU) ? {{(DW-1){1'b0}}, bus.in_set} : bus.in_result;
        captured.zero       = bus.in_zero;
        captured.rd         = bus.in_rd;
        captured.reg_write  = bus.in_reg_write;
        captured.mem_read   = bus.in_mem_read;
        captured.mem_write  = bus.in_mem_write;
        captured.store_data = bus.in_store_data;
        ovf_hit             = 1'b0;
`ifdef EXMEM_OVF_TRAP_EN
        ovf_hit = bus.in_overflow && ((bus.in_op == OP_ADD) || (bus.in_op == OP_SUB));
        if (ovf_hit) begin
            captured.reg_write = 1'b0;
            captured.mem_read  = 1'b0;
            captured.mem_write = 1'b0;
        end
`endif
    end

`ifndef EXMEM_OVF_TRAP_EN
    logic unused_ovf;
    assign unused_ovf = bus.in_overflow ^ (OP_ADD == OP_SUB);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                load_head_in = 1'b1;
                state_nxt    = ONE;
            end
            ONE: begin
                if (accept && pop) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (pop) begin
                load_head_skid = 1'b1;
                state_nxt      = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
        if (bus.flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head   <= '0;
            skid   <= '0;
            trap_q <= 1'b0;
        end else begin
            if (load_head_in)   head <= captured;
            if (load_head_skid) head <= skid;
            if (load_skid)      skid <= captured;
            if (bus.flush)                trap_q <= 1'b0;
            else if (accept && ovf_hit)   trap_q <= 1'b1;
        end
    end

    assign bus.in_ready       = (state != FULL);
    assign bus.out_valid      = (state != EMPTY);
    assign bus.out_value      = head.value;
    assign bus.out_zero       = head.zero;
    assign bus.out_rd         = head.rd;
    assign bus.out_reg_write  = head.reg_write;
    assign bus.out_mem_read   = head.mem_read;
    assign bus.out_mem_write  = head.mem_write;
    assign bus.out_store_data = head.store_data;
    assign bus.fwd_valid      = bus.out_valid && head.reg_write && (head.rd != '0);
    assign bus.fwd_rd         = head.rd;
    assign bus.fwd_data       = head.value;
    assign bus.fwd_busy       = (state == FULL);
    assign bus.trap_ovf       = trap_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: queue scoreboard of expected head entries plus occupancy model.
module tb_ex_mem_stage;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_SLTU = 5'b00111;
`ifdef EXMEM_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] value;
        logic        zero;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic [31:0] sd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    bit   trap_m = 1'b0;

    ex_mem_if #(.DW(32), .RW(5), .OPW(5)) bus ();
    ex_mem_stage #(.DW(32), .RW(5), .OPW(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] res, input logic set,
                                   input logic ovf, input logic [4:0] rd, input logic rw,
                                   input logic mr, input logic mw, input logic [31:0] sd);
        exp_t e;
        bit   squash;
        squash  = TRAP && ovf && (op == OP_ADD || op == OP_SUB);
        e.value = (op == OP_SLTU) ? {31'b0, set} : res;
        e.zero  = (res == 32'h0);
        e.rd    = rd;
        e.rw    = rw && !squash;
        e.mr    = mr && !squash;
        e.mw    = mw && !squash;
        e.sd    = sd;
        return e;
    endfunction

    task automatic check_outputs();
        int occ = q.size();
        chk("in_ready",  bus.in_ready,  occ < 2);
        chk("out_valid", bus.out_valid, occ > 0);
        chk("fwd_busy",  bus.fwd_busy,  occ == 2);
        chk("trap_ovf",  bus.trap_ovf,  trap_m);
        if (occ > 0) begin
            chk("out_value",      bus.out_value,      q[0].value);
            chk("out_zero",       bus.out_zero,       q[0].zero);
            chk("out_rd",         bus.out_rd,         q[0].rd);
            chk("out_reg_write",  bus.out_reg_write,  q[0].rw);
            chk("out_mem_read",   bus.out_mem_read,   q[0].mr);
            chk("out_mem_write",  bus.out_mem_write,  q[0].mw);
            chk("out_store_data", bus.out_store_data, q[0].sd);
            chk("fwd_valid",      bus.fwd_valid,      q[0].rw && q[0].rd != 5'd0);
            chk("fwd_rd",         bus.fwd_rd,         q[0].rd);
            chk("fwd_data",       bus.fwd_data,       q[0].value);
        end else begin
            chk("fwd_valid_empty", bus.fwd_valid, 1'b0);
        end
    endtask

    // Called just after a falling edge: drive, check, update model, advance one cycle.
    task automatic step(input logic v, input logic [4:0] op, input logic [31:0] res, input logic set,
                        input logic ovf, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic [31:0] sd, input logic rdy, input logic fl);
        bit acc, pp;
        bus.in_valid      = v;
        bus.in_op         = op;
        bus.in_result     = res;
        bus.in_set        = set;
        bus.in_zero       = (res == 32'h0);
        bus.in_overflow   = ovf;
        bus.in_rd         = rd;
        bus.in_reg_write  = rw;
        bus.in_mem_read   = mr;
        bus.in_mem_write  = mw;
        bus.in_store_data = sd;
        bus.out_ready     = rdy;
        bus.flush         = fl;
        #1;
        check_outputs();
        acc = v && (q.size() < 2) && !fl;
        pp  = (q.size() > 0) && rdy && !fl;
        if (fl) begin
            q.delete();
            trap_m = 1'b0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(model(op, res, set, ovf, rd, rw, mr, mw, sd));
                if (TRAP && ovf && (op == OP_ADD || op == OP_SUB)) trap_m = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, OP_OR, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_result = '0; bus.in_set = 1'b0;
        bus.in_zero = 1'b0; bus.in_overflow = 1'b0; bus.in_rd = '0; bus.in_reg_write = 1'b0;
        bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0; bus.in_store_data = '0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_value", bus.out_value, 32'h0);
        chk("rst_trap",      bus.trap_ovf,  1'b0);
        chk("rst_fwd_busy",  bus.fwd_busy,  1'b0);
        reset = 1'b0;
        @(negedge clk);

        // basic add with forwarding
        step(1'b1, OP_ADD, 32'h5, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        // sltu normalisation
        step(1'b1, OP_SLTU, 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, OP_SLTU, 32'hFFFF_FFFE, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        // backpressure: A, B captured, C held while full, then drain in order
        step(1'b1, OP_OR, 32'hA, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, OP_OR, 32'hB, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, OP_OR, 32'hC, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, OP_OR, 32'hC, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, OP_OR, 32'hC, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, OP_OR, 32'hC, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        // flush while full with a valid input
        step(1'b1, OP_OR, 32'h11, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, OP_OR, 32'h22, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, OP_OR, 32'h33, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        // rd=0 suppresses forwarding; store passes through; load
        step(1'b1, OP_ADD, 32'h77, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, OP_ADD, 32'h100, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        step(1'b1, OP_ADD, 32'h0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        // overflowing add, trap sticky until flush
        step(1'b1, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, OP_SUB, 32'h7FFF_FFFF, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 32'h1, 1'b1, 1'b0);
        step(1'b1, OP_OR, 32'h5, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, OP_OR, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        idle(1'b1);
        // random valid/ready traffic
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? OP_SLTU : OP_OR,
                 $urandom, 1'($urandom), 1'b0, 5'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom, 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        // asynchronous reset mid-transfer
        step(1'b1, OP_OR, 32'h44, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, OP_OR, 32'h55, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_in_ready",  bus.in_ready,  1'b1);
        chk("arst_out_value", bus.out_value, 32'h0);
        chk("arst_fwd_busy",  bus.fwd_busy,  1'b0);
        q.delete();
        trap_m = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, OP_ADD, 32'h9, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
